ssd1306_microcode_sequencer: RTL
================================

Name: ssd1306_microcode_sequencer

Overview:
Reads the SSD1306 microcode ROM word by word and executes it: command and data bytes go to the SPI byte transmitter with the D/C flag, delay words produce timed pauses, and an end word (or address overflow) stops the run. It sits between the display controller's start request and the SPI transmitter. It owns the ROM address and never modifies ROM contents.

Parameters:
ROM_SIZE, 40, number of microcode words; ROM address width is $clog2(ROM_SIZE)
DATA_WIDTH, 10, microcode word width; fixed format below, must be 10
DELAY_UNIT, 1000, clock cycles per delay count (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begin execution at address 0
busy  out  1  high from the accepted start until the run completes
done  out  1  one-cycle pulse when the run completes
rom_address  out  $clog2(ROM_SIZE)  ROM address, driven from a register
rom_data  in  DATA_WIDTH  ROM word, combinational from rom_address
rom_address_overflow  in  1  ROM flag: address >= ROM_SIZE
tx_valid  out  1  byte offered to the SPI transmitter
tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
tx_byte  out  8  byte to transmit
tx_dc  out  1  0 = command byte, 1 = data byte (SSD1306 D/C pin)

Behaviour:
- Reset: the state goes to IDLE. All outputs reset as follows: rom_address=0, busy=0, done=0, tx_valid=0, tx_byte=0, tx_dc=0. Reset mid-run aborts immediately, with no done pulse, and overrides every other input in that cycle.
- Word format: [9:8] opcode, [7:0] operand.
  - 00: CMD. Send the operand with dc=0.
  - 01: DATA. Send the operand with dc=1.
  - 10: DELAY. Wait operand*DELAY_UNIT cycles; operand 0 means no wait.
  - 11: END. Stop the run.
- States: IDLE, FETCH, SEND, DELAY, FINISH.
- IDLE: busy=0. When start=1, set rom_address=0 and busy=1, then go to FETCH. start is ignored in every other state.
- FETCH: rom_address is stable, so sample rom_data and rom_address_overflow this cycle.
  - overflow=1 or opcode END: go to FINISH.
  - CMD/DATA: load tx_byte and tx_dc, set tx_valid=1, go to SEND.
  - DELAY with operand 0: increment rom_address and stay in FETCH.
  - DELAY with operand >0: load the counter with operand*DELAY_UNIT-1 and go to DELAY.
- SEND: tx_valid stays high, and tx_byte/tx_dc stay stable until tx_ready. In the handshake cycle, tx_valid is cleared, rom_address increments, and the state goes to FETCH. Latency is one FETCH cycle per word, so the minimum byte cadence is 2 cycles when tx_ready is held high.
- DELAY: the counter decrements each cycle. At 0, rom_address increments and the state goes to FETCH. The total is exactly operand*DELAY_UNIT cycles in DELAY.
- Counter width: $clog2(255*DELAY_UNIT+1) bits. Compute the product at that width, with no truncation.
- Address increment: when rom_address = ROM_SIZE-1, the next address is ROM_SIZE. Do not wrap the counter to 0; the next FETCH then sees overflow and ends the run.
  - The address register is $clog2(ROM_SIZE) bits. If ROM_SIZE is a power of two, the increment wraps to 0. In that case terminate on the carry out: flag it internally and treat it as overflow.
- FINISH: one cycle with done=1. busy is cleared at the same clock edge, so busy=0 and done=1 are both visible in the FINISH cycle. Then go to IDLE.
- A start arriving on the same cycle as done is ignored; a new start is accepted from IDLE only.

Decomposition:
- Package ssd1306_pkg holds:
  - the opcode enum: OP_CMD=2'b00, OP_DATA=2'b01, OP_DELAY=2'b10, OP_END=2'b11;
  - the state enum;
  - the field localparams OPCODE_MSB=9, OPCODE_LSB=8, OPERAND_MSB=7.
- Sub-module ssd1306_delay_timer (load value, count, expired flag) is the one natural split; the rest stays flat.

Test Plan:
- ROM {0x0AE, 0x1A5, 0x300}, start pulse, tx_ready=1: bytes 0xAE dc=0 then 0xA5 dc=1, each with tx_valid for 1 cycle; done pulses once and busy returns to 0.
- The same ROM with tx_ready low for 5 cycles on the first byte: tx_valid held for 6 cycles and tx_byte stays 0xAE throughout; address does not advance until the handshake.
- DELAY_UNIT=4, ROM {0x203, 0x0AF, 0x300}: exactly 12 cycles in DELAY before 0xAF is offered; word 0x200 causes no stall.
- ROM of 40 CMD words with no END: 40 bytes sent, then done as the 41st fetch sees overflow; rom_address is never 0 after the start.
- rst asserted while SEND waits with tx_ready=0: the next cycle shows tx_valid=0, busy=0, rom_address=0, and no done pulse; a subsequent start reruns from word 0.
- A start pulse while busy has no effect; a start arriving in the done cycle is ignored, and a start on the following cycle is accepted.

Source files
------------

// File: rtl/ssd1306_microcode_sequencer_pkg.sv
// Shared types and microcode word field positions for the SSD1306 microcode sequencer.
package ssd1306_pkg;

   typedef enum logic [1:0] {
      OP_CMD   = 2'b00,
      OP_DATA  = 2'b01,
      OP_DELAY = 2'b10,
      OP_END   = 2'b11
   } opcode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND,
      ST_DELAY,
      ST_FINISH
   } state_t;

   localparam int unsigned OPCODE_MSB  = 9;
   localparam int unsigned OPCODE_LSB  = 8;
   localparam int unsigned OPERAND_MSB = 7;

endpackage

// File: rtl/ssd1306_microcode_sequencer_delay_timer.sv
// Loadable down-counter for microcode delays; expired while the count sits at zero.
module ssd1306_delay_timer #(
   parameter int unsigned CW = 18
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_value,
   input  logic          i_count_en,
   output logic          o_expired
);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_count_en && (r_count != '0)) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign o_expired = (r_count == '0);

endmodule

// File: rtl/ssd1306_microcode_sequencer.sv
// Fetches SSD1306 microcode words and executes them: CMD/DATA bytes to the SPI
// transmitter, timed delays, and END or address overflow to finish the run.
module ssd1306_microcode_sequencer
   import ssd1306_pkg::*;
#(
   parameter int unsigned ROM_SIZE   = 40,
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned DELAY_UNIT = 1000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic [$clog2(ROM_SIZE)-1:0] rom_address,
   input  logic [DATA_WIDTH-1:0]       rom_data,
   input  logic                        rom_address_overflow,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   output logic [7:0]                  tx_byte,
   output logic                        tx_dc
);

   localparam int unsigned AW = $clog2(ROM_SIZE);
   localparam int unsigned CW = $clog2(255 * DELAY_UNIT + 1);
   localparam logic [CW-1:0] DU = CW'(DELAY_UNIT);

   state_t        r_state, w_state_nx;
   logic [AW-1:0] r_addr, w_addr_nx;
   logic          r_carry, w_carry_nx;
   logic          r_busy, w_busy_nx;
   logic          r_valid, w_valid_nx;
   logic [7:0]    r_byte, w_byte_nx;
   logic          r_dc, w_dc_nx;

   opcode_t       w_op;
   logic [7:0]    w_operand;
   logic [AW:0]   w_addr_inc;
   logic [CW-1:0] w_delay_load;
   logic          w_load;
   logic          w_cnt_en;
   logic          w_expired;
   logic          w_stop;

   assign w_op         = opcode_t'(rom_data[OPCODE_MSB:OPCODE_LSB]);
   assign w_operand    = rom_data[OPERAND_MSB:0];
   assign w_addr_inc   = {1'b0, r_addr} + (AW+1)'(1);
   assign w_delay_load = (CW'(w_operand) * DU) - CW'(1);
   // A power-of-two ROM wraps the address to 0; the latched carry stands in for overflow.
   assign w_stop       = rom_address_overflow || r_carry || (w_op == OP_END);

   ssd1306_delay_timer #(
      .CW (CW)
   ) u_delay_timer (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_load),
      .i_load_value (w_delay_load),
      .i_count_en   (w_cnt_en),
      .o_expired    (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_carry <= 1'b0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_byte  <= '0;
         r_dc    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_addr  <= w_addr_nx;
         r_carry <= w_carry_nx;
         r_busy  <= w_busy_nx;
         r_valid <= w_valid_nx;
         r_byte  <= w_byte_nx;
         r_dc    <= w_dc_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_carry_nx = r_carry;
      w_busy_nx  = r_busy;
      w_valid_nx = r_valid;
      w_byte_nx  = r_byte;
      w_dc_nx    = r_dc;
      w_load     = 1'b0;
      w_cnt_en   = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_addr_nx  = '0;
               w_carry_nx = 1'b0;
               w_busy_nx  = 1'b1;
               w_state_nx = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (w_stop) begin
               w_busy_nx  = 1'b0;
               w_state_nx = ST_FINISH;
            end else begin
               case (w_op)
                  OP_CMD, OP_DATA: begin
                     w_byte_nx  = w_operand;
                     w_dc_nx    = (w_op == OP_DATA);
                     w_valid_nx = 1'b1;
                     w_state_nx = ST_SEND;
                  end
                  OP_DELAY: begin
                     if (w_operand == '0) begin
                        {w_carry_nx, w_addr_nx} = w_addr_inc;
                     end else begin
                        w_load     = 1'b1;
                        w_state_nx = ST_DELAY;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               w_valid_nx              = 1'b0;
               {w_carry_nx, w_addr_nx} = w_addr_inc;
               w_state_nx              = ST_FETCH;
            end
         end
         ST_DELAY: begin
            w_cnt_en = 1'b1;
            if (w_expired) begin
               {w_carry_nx, w_addr_nx} = w_addr_inc;
               w_state_nx              = ST_FETCH;
            end
         end
         ST_FINISH: begin
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   assign busy        = r_busy;
   assign done        = (r_state == ST_FINISH);
   assign rom_address = r_addr;
   assign tx_valid    = r_valid;
   assign tx_byte     = r_byte;
   assign tx_dc       = r_dc;

endmodule
